clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-set controller for the hours/minutes/seconds wall-clock counter. It decodes two cleaned push-button levels (mode, increment) into a four-state edit sequence. While the user edits, it holds the counter stopped and keeps shadow hour/minute values. On exit it issues a one-cycle load pulse that writes the edited time into the counter. It sits between the front-panel button logic and the counter's enable/load inputs.

## Interface
- `REPEAT_DELAY`, default 32: cycles `inc_btn` must stay held before auto-repeat starts; must be ≥ `REPEAT_RATE`.
- `REPEAT_RATE`, default 8: cycles between auto-repeat increments; must be ≥ 1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode_btn`  in  1  debounced, synchronous mode button level.
- `inc_btn`  in  1  debounced, synchronous increment button level.
- `cur_hr`  in  6  live hour value from the counter (0–23).
- `cur_min`  in  6  live minute value from the counter (0–59).
- `run_en`  out  1  counter count enable; 1 only in RUN.
- `load`  out  1  one-cycle pulse: counter loads `load_hr`/`load_min` and clears seconds.
- `load_hr`  out  6  edited hour (shadow register).
- `load_min`  out  6  edited minute (shadow register).
- `state`  out  2  current state: RUN=0, SET_HR=1, SET_MIN=2, COMMIT=3.

## Operation
- **Edge detection.** Registered copies of `mode_btn` and `inc_btn` give the edges. `mode_rise = mode_btn & ~mode_q`, likewise `inc_rise`.
- **RUN.** `run_en=1`. On `mode_rise`:
  - capture `cur_hr` into `edit_hr` and `cur_min` into `edit_min`;
  - a captured hour > 23 loads as 0; a captured minute > 59 loads as 0;
  - go to SET_HR.
  - `inc_rise` is ignored in RUN.
- **SET_HR.** `run_en=0`.
  - Each increment event: `edit_hr = (edit_hr==23) ? 0 : edit_hr+1`.
  - `mode_rise` goes to SET_MIN.
- **SET_MIN.** `run_en=0`.
  - Each increment event: `edit_min = (edit_min==59) ? 0 : edit_min+1`.
  - `mode_rise` goes to COMMIT.
- **COMMIT.** `run_en=0`, `load=1` for exactly this cycle, then unconditionally go to RUN. Button edges in COMMIT are ignored.
- **Simultaneous edges.** When `mode_rise` and an increment event arrive in the same cycle, mode wins: the state advances and the edit register is not incremented.
- **Outputs.** `load_hr`/`load_min` always drive `edit_hr`/`edit_min`. They are only meaningful while `load=1`.
- **Increment event.** `inc_rise`, plus auto-repeat ticks when configured (see Configuration).
- **Reset values.** Asserting `rst` at any time, including mid-edit, forces:
  - `state=RUN`, `run_en=1`, `load=0`;
  - `load_hr=0`, `load_min=0`;
  - edge registers and repeat counter to 0.
  - Edits in progress are discarded and no load is issued.

## Timing
- Edge seen in cycle n (sampled at the rising edge ending cycle n): the state and edit update are visible in cycle n+1.
- Mode edge in RUN at n: `run_en=0` and `state=SET_HR` at n+1. The counter gets no further increments from then on.
- Mode edge in SET_MIN at n: `load=1` at n+1, `run_en=1` and `state=RUN` at n+2.
- Latency from the final mode press to load is 1 cycle. The load pulse width is always exactly 1 cycle.
- A button held high generates exactly one edge. No further edge occurs until it is seen low for at least 1 cycle.

## Configuration
- Macro: `CLOCK_SET_AUTO_REPEAT_EN`.
- **Defined.**
  - In SET_HR/SET_MIN, a hold counter starts at `inc_rise` and counts cycles while `inc_btn` stays 1.
  - When the count reaches `REPEAT_DELAY`, one increment event fires. A further event fires every `REPEAT_RATE` cycles after that while the button is held.
  - The hold counter clears on `inc_btn=0`, on any state change, and on reset.
  - Counter width is `$clog2(REPEAT_DELAY+1)`; it saturates and never wraps.
- **Undefined.** Only `inc_rise` increments. No hold counter is synthesized.

## Test plan
- **Reset mid-edit.** Reset, then mode press with `cur_hr=10`, `cur_min=45` → SET_HR the next cycle with `load_hr=10`, `load_min=45`, `run_en=0`. Assert `rst` → state=0, `run_en=1`, `load_hr=0`, `load_min=0`, and no load pulse ever appears.
- **Full edit sequence.** Enter SET_HR from `cur_hr=22`. Two inc presses → `load_hr=0` (22→23→0 wrap). Mode press, then `cur_min=58` captured earlier plus three inc presses → `load_min=1`. Mode press → `load=1` for exactly 1 cycle, then `run_en=1`.
- **Simultaneous edges.** `mode_btn` and `inc_btn` rise in the same cycle while in SET_HR with `edit_hr=5` → state=SET_MIN and `edit_hr` stays 5.
- **Out-of-range capture and ignored inc.** Capture `cur_hr=30`, `cur_min=63` → `edit_hr=0`, `edit_min=0`. An inc press in RUN → no change to any output.
- **Auto-repeat (macro defined, DELAY=32, RATE=8).** Hold `inc_btn` for 60 cycles in SET_MIN from 0 → 1 + 1 + 3 = 5 increments, `load_min=5`.
- **No auto-repeat (macro undefined).** Same stimulus → `load_min=1`.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// Front-panel / counter connection bundle for clock_set_ctrl.
// master: button logic plus wall-clock counter side (drives buttons, live time).
// slave : the time-set controller itself.
interface clock_set_ctrl_if;
    logic       mode_btn;
    logic       inc_btn;
    logic [5:0] cur_hr;
    logic [5:0] cur_min;
    logic       run_en;
    logic       load;
    logic [5:0] load_hr;
    logic [5:0] load_min;
    logic [1:0] state;

    modport master (
        output mode_btn, inc_btn, cur_hr, cur_min,
        input  run_en, load, load_hr, load_min, state
    );

    modport slave (
        input  mode_btn, inc_btn, cur_hr, cur_min,
        output run_en, load, load_hr, load_min, state
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-set controller for the hours/minutes/seconds wall-clock counter.
// Walks RUN -> SET_HR -> SET_MIN -> COMMIT on mode presses, keeps shadow
// hour/minute registers while editing and pulses load for one cycle on exit.
// Optional feature macro: CLOCK_SET_AUTO_REPEAT_EN enables auto-repeat of
// the increment button while it is held in SET_HR/SET_MIN.
module clock_set_ctrl #(
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic              clk,
    input  logic              rst,
    clock_set_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    // Parameter sanity: reject configurations the repeat logic cannot honour.
    if ((REPEAT_RATE < 1) || (REPEAT_DELAY < REPEAT_RATE)) begin : g_bad_params
        $error("clock_set_ctrl: need REPEAT_RATE >= 1 and REPEAT_DELAY >= REPEAT_RATE");
    end

    // Next hour with wrap 23 -> 0.
    function automatic logic [5:0] hr_next(input logic [5:0] h);
        return (h == 6'd23) ? 6'd0 : (h + 6'd1);
    endfunction

    // Next minute with wrap 59 -> 0.
    function automatic logic [5:0] min_next(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : (m + 6'd1);
    endfunction

    // Out-of-range live values are treated as 0 when captured.
    function automatic logic [5:0] hr_clamp(input logic [5:0] h);
        return (h > 6'd23) ? 6'd0 : h;
    endfunction

    function automatic logic [5:0] min_clamp(input logic [5:0] m);
        return (m > 6'd59) ? 6'd0 : m;
    endfunction

    state_t     state_r;
    logic       run_en_r;
    logic       load_r;
    logic [5:0] edit_hr_r;
    logic [5:0] edit_min_r;
    logic       mode_q_r;
    logic       inc_q_r;

    logic       mode_rise_s;
    logic       inc_rise_s;
    logic       inc_evt_s;
    logic       in_set_s;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(REPEAT_DELAY);
    // Reloading here after a tick makes the next tick land exactly
    // REPEAT_RATE cycles later; the value is never 0, so 0 means idle.
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);

    logic [CNT_W-1:0] hold_cnt_r;
    logic             rep_tick_s;
`endif

    // Edge detection and increment-event qualification.
    always_comb begin
        mode_rise_s = bus.mode_btn & ~mode_q_r;
        inc_rise_s  = bus.inc_btn & ~inc_q_r;
        in_set_s    = (state_r == ST_SET_HR) || (state_r == ST_SET_MIN);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        rep_tick_s  = in_set_s && bus.inc_btn && !inc_rise_s && (hold_cnt_r == CNT_MAX);
        inc_evt_s   = inc_rise_s | rep_tick_s;
`else
        inc_evt_s   = inc_rise_s;
`endif
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    // Hold counter: starts at an increment edge, saturates at REPEAT_DELAY,
    // reloads after each repeat tick, clears on release or any state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= '0;
        end else if (!in_set_s || mode_rise_s || !bus.inc_btn) begin
            hold_cnt_r <= '0;
        end else if (inc_rise_s) begin
            hold_cnt_r <= CNT_W'(1);
        end else if (hold_cnt_r == CNT_MAX) begin
            hold_cnt_r <= CNT_RELOAD;
        end else if (hold_cnt_r != '0) begin
            hold_cnt_r <= hold_cnt_r + CNT_W'(1);
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end
`endif

    // Edit-sequence FSM with registered outputs and shadow time registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            run_en_r   <= 1'b1;
            load_r     <= 1'b0;
            edit_hr_r  <= 6'd0;
            edit_min_r <= 6'd0;
            mode_q_r   <= 1'b0;
            inc_q_r    <= 1'b0;
        end else begin
            mode_q_r <= bus.mode_btn;
            inc_q_r  <= bus.inc_btn;
            load_r   <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (mode_rise_s) begin
                        edit_hr_r  <= hr_clamp(bus.cur_hr);
                        edit_min_r <= min_clamp(bus.cur_min);
                        state_r    <= ST_SET_HR;
                        run_en_r   <= 1'b0;
                    end else begin
                        run_en_r   <= 1'b1;
                    end
                end
                ST_SET_HR: begin
                    run_en_r <= 1'b0;
                    if (mode_rise_s) begin
                        state_r <= ST_SET_MIN;
                    end else if (inc_evt_s) begin
                        edit_hr_r <= hr_next(edit_hr_r);
                    end else begin
                        edit_hr_r <= edit_hr_r;
                    end
                end
                ST_SET_MIN: begin
                    run_en_r <= 1'b0;
                    if (mode_rise_s) begin
                        state_r <= ST_COMMIT;
                        load_r  <= 1'b1;
                    end else if (inc_evt_s) begin
                        edit_min_r <= min_next(edit_min_r);
                    end else begin
                        edit_min_r <= edit_min_r;
                    end
                end
                ST_COMMIT: begin
                    state_r  <= ST_RUN;
                    run_en_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_RUN;
                    run_en_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.run_en   = run_en_r;
    assign bus.load     = load_r;
    assign bus.load_hr  = edit_hr_r;
    assign bus.load_min = edit_min_r;
    assign bus.state    = state_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl.
module tb_clock_set_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   load_cycles;

    clock_set_ctrl_if bus_if ();

    clock_set_ctrl #(
        .REPEAT_DELAY (32),
        .REPEAT_RATE  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which load is seen high (sampled on falling edge).
    always @(negedge clk) begin
        if (bus_if.load === 1'b1) load_cycles = load_cycles + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mode_press();
        bus_if.mode_btn = 1'b1;
        cyc();
        bus_if.mode_btn = 1'b0;
        cyc();
    endtask

    task automatic inc_press();
        bus_if.inc_btn = 1'b1;
        cyc();
        bus_if.inc_btn = 1'b0;
        cyc();
    endtask

    int exp_rep_min;
    int loads_before;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        load_cycles = 0;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        exp_rep_min = 5;
`else
        exp_rep_min = 1;
`endif
        bus_if.mode_btn = 1'b0;
        bus_if.inc_btn  = 1'b0;
        bus_if.cur_hr   = 6'd0;
        bus_if.cur_min  = 6'd0;
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Reset state
        check_val("rst_state",    bus_if.state,    0);
        check_val("rst_run_en",   bus_if.run_en,   1);
        check_val("rst_load",     bus_if.load,     0);
        check_val("rst_load_hr",  bus_if.load_hr,  0);
        check_val("rst_load_min", bus_if.load_min, 0);

        // Reset mid-edit
        bus_if.cur_hr  = 6'd10;
        bus_if.cur_min = 6'd45;
        bus_if.mode_btn = 1'b1;
        cyc();
        check_val("edit_state",   bus_if.state,    1);
        check_val("edit_hr",      bus_if.load_hr,  10);
        check_val("edit_min",     bus_if.load_min, 45);
        check_val("edit_run_en",  bus_if.run_en,   0);
        bus_if.mode_btn = 1'b0;
        cyc();
        mode_press();
        rst = 1'b1;
        #1;
        check_val("mid_rst_state",   bus_if.state,    0);
        check_val("mid_rst_run_en",  bus_if.run_en,   1);
        check_val("mid_rst_load_hr", bus_if.load_hr,  0);
        check_val("mid_rst_load_min",bus_if.load_min, 0);
        cyc();
        rst = 1'b0;
        repeat (5) cyc();
        check_val("mid_rst_no_load", load_cycles, 0);

        // Full edit sequence with hour and minute wrap
        bus_if.cur_hr  = 6'd22;
        bus_if.cur_min = 6'd58;
        mode_press();
        check_val("seq_state_hr", bus_if.state,   1);
        check_val("seq_hr_cap",   bus_if.load_hr, 22);
        inc_press();
        check_val("seq_hr_23",    bus_if.load_hr, 23);
        inc_press();
        check_val("seq_hr_wrap",  bus_if.load_hr, 0);
        mode_press();
        check_val("seq_state_min", bus_if.state,    2);
        check_val("seq_min_cap",   bus_if.load_min, 58);
        inc_press();
        inc_press();
        inc_press();
        check_val("seq_min_wrap",  bus_if.load_min, 1);
        loads_before = load_cycles;
        bus_if.mode_btn = 1'b1;
        cyc();
        check_val("seq_commit_state", bus_if.state,    3);
        check_val("seq_load",         bus_if.load,     1);
        check_val("seq_commit_run",   bus_if.run_en,   0);
        check_val("seq_commit_hr",    bus_if.load_hr,  0);
        check_val("seq_commit_min",   bus_if.load_min, 1);
        bus_if.mode_btn = 1'b0;
        cyc();
        check_val("seq_back_state", bus_if.state,  0);
        check_val("seq_back_run",   bus_if.run_en, 1);
        check_val("seq_back_load",  bus_if.load,   0);
        repeat (2) cyc();
        check_val("seq_load_width", load_cycles - loads_before, 1);

        // Simultaneous mode and inc edges: mode wins
        bus_if.cur_hr  = 6'd5;
        bus_if.cur_min = 6'd0;
        mode_press();
        check_val("sim_pre_hr", bus_if.load_hr, 5);
        bus_if.mode_btn = 1'b1;
        bus_if.inc_btn  = 1'b1;
        cyc();
        check_val("sim_state", bus_if.state,   2);
        check_val("sim_hr",    bus_if.load_hr, 5);
        bus_if.mode_btn = 1'b0;
        bus_if.inc_btn  = 1'b0;
        cyc();
        mode_press();
        check_val("sim_back_state", bus_if.state, 0);

        // Inc press in RUN is ignored
        bus_if.cur_hr = 6'd7;
        inc_press();
        check_val("run_inc_state",  bus_if.state,    0);
        check_val("run_inc_run_en", bus_if.run_en,   1);
        check_val("run_inc_hr",     bus_if.load_hr,  5);
        check_val("run_inc_min",    bus_if.load_min, 0);
        check_val("run_inc_load",   bus_if.load,     0);

        // Out-of-range capture
        bus_if.cur_hr  = 6'd30;
        bus_if.cur_min = 6'd63;
        mode_press();
        check_val("oor_state", bus_if.state,    1);
        check_val("oor_hr",    bus_if.load_hr,  0);
        check_val("oor_min",   bus_if.load_min, 0);

        // Held increment for 60 cycles in SET_MIN
        mode_press();
        check_val("hold_state", bus_if.state, 2);
        bus_if.inc_btn = 1'b1;
        repeat (60) cyc();
        bus_if.inc_btn = 1'b0;
        repeat (2) cyc();
        check_val("hold_min", bus_if.load_min, exp_rep_min);
        bus_if.mode_btn = 1'b1;
        cyc();
        check_val("hold_load",     bus_if.load,     1);
        check_val("hold_load_min", bus_if.load_min, exp_rep_min);
        bus_if.mode_btn = 1'b0;
        repeat (2) cyc();
        check_val("hold_back_state", bus_if.state, 0);
        check_val("total_loads", load_cycles, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
